// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Segment words are active-low {dp,g,f,e,d,c,b,a}.
package disp_pkg;

   typedef enum logic [1:0] {
      ST_LIVE     = 2'd0,
      ST_SHOW     = 2'd1,
      ST_WAIT_LOW = 2'd2
   } state_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Index n holds the glyph for hex digit n, decimal point off.
   localparam logic [15:0][7:0] HEX_FONT = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/disp_scheduler_if.sv
// Handshake and display bus between the display scheduler and its clients.
interface disp_scheduler_if;
   logic        tick;
   logic [15:0] live_val;
   logic        live_en;
   logic        msg_req;
   logic [31:0] msg_data;
   logic        msg_blink;
   logic        msg_ack;
   logic [7:0]  seg0;
   logic [7:0]  seg1;
   logic [7:0]  seg2;
   logic [7:0]  seg3;
   logic        owner;
   logic        busy;

   modport master (
      output tick, live_val, live_en, msg_req, msg_data, msg_blink,
      input  msg_ack, seg0, seg1, seg2, seg3, owner, busy
   );

   modport slave (
      input  tick, live_val, live_en, msg_req, msg_data, msg_blink,
      output msg_ack, seg0, seg1, seg2, seg3, owner, busy
   );
endinterface

// File: rtl/disp_scheduler_hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph, dp off.
module hex7seg
   import disp_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [7:0] o_seg
);
   assign o_seg = HEX_FONT[i_nib];
endmodule

// File: rtl/disp_scheduler.sv
// Arbitrates the 4-digit display between the live hex value and a timed,
// optionally blinking overlay message; all outputs are registered.
module disp_scheduler
   import disp_pkg::*;
#(
   parameter int HOLD_TICKS = 8,
   parameter int BLINK_DIV  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   disp_scheduler_if.slave  bus_if
);

   localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
   localparam int DIV_EFF  = (BLINK_DIV < 1) ? 1 : BLINK_DIV;
   localparam int HW       = $clog2(HOLD_EFF + 1);
   localparam int BW       = $clog2(DIV_EFF + 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_EFF);
   localparam logic [BW-1:0] BLINK_LAST = BW'(DIV_EFF - 1);

   state_e          r_state;
   logic [HW-1:0]   r_hold;
   logic [BW-1:0]   r_blink_cnt;
   logic            r_phase_blank;
   logic [31:0]     r_msg_data;
   logic            r_msg_blink;
   logic [7:0]      r_seg [4];
   logic            r_ack;
   logic            r_owner;
   logic            r_busy;

   logic [7:0]      w_live_dec [4];
   logic [7:0]      w_live_seg [4];
   logic [7:0]      w_req_seg  [4];
   logic [7:0]      w_msg_seg  [4];
   logic            w_blink_wrap;
   logic            w_phase_next;
   logic            w_final;

   assign w_blink_wrap = r_msg_blink & bus_if.tick & (r_blink_cnt == BLINK_LAST);
   assign w_phase_next = r_phase_blank ^ w_blink_wrap;
   assign w_final      = bus_if.tick & (r_hold == HW'(1));

   // Digit gi takes nibble/byte gi counting from the most significant end.
   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      hex7seg u_dec (
         .i_nib (bus_if.live_val[15-4*gi -: 4]),
         .o_seg (w_live_dec[gi])
      );
      assign w_live_seg[gi] = bus_if.live_en ? w_live_dec[gi] : SEG_BLANK;
      assign w_req_seg[gi]  = bus_if.msg_data[31-8*gi -: 8];
      assign w_msg_seg[gi]  = w_phase_next ? SEG_BLANK : r_msg_data[31-8*gi -: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_LIVE;
         r_hold        <= '0;
         r_blink_cnt   <= '0;
         r_phase_blank <= 1'b0;
         r_msg_data    <= '0;
         r_msg_blink   <= 1'b0;
         r_ack         <= 1'b0;
         r_owner       <= 1'b0;
         r_busy        <= 1'b0;
         for (int i = 0; i < 4; i++) r_seg[i] <= SEG_BLANK;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_LIVE: begin
               if (bus_if.msg_req) begin
                  r_state       <= ST_SHOW;
                  r_msg_data    <= bus_if.msg_data;
                  r_msg_blink   <= bus_if.msg_blink;
                  r_ack         <= 1'b1;
                  r_owner       <= 1'b1;
                  r_busy        <= 1'b1;
                  r_hold        <= HOLD_LOAD;
                  r_blink_cnt   <= '0;
                  r_phase_blank <= 1'b0;
                  for (int i = 0; i < 4; i++) r_seg[i] <= w_req_seg[i];
               end else begin
                  r_owner <= 1'b0;
                  r_busy  <= 1'b0;
                  for (int i = 0; i < 4; i++) r_seg[i] <= w_live_seg[i];
               end
            end
            ST_SHOW: begin
               if (w_final) begin
                  r_state       <= bus_if.msg_req ? ST_WAIT_LOW : ST_LIVE;
                  r_hold        <= '0;
                  r_blink_cnt   <= '0;
                  r_phase_blank <= 1'b0;
                  r_owner       <= 1'b0;
                  r_busy        <= bus_if.msg_req;
                  for (int i = 0; i < 4; i++) r_seg[i] <= w_live_seg[i];
               end else begin
                  if (bus_if.tick) begin
                     r_hold <= r_hold - 1'b1;
                     if (r_msg_blink)
                        r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
                  end
                  r_phase_blank <= w_phase_next;
                  r_owner       <= 1'b1;
                  r_busy        <= 1'b1;
                  for (int i = 0; i < 4; i++) r_seg[i] <= w_msg_seg[i];
               end
            end
            ST_WAIT_LOW: begin
               if (!bus_if.msg_req) r_state <= ST_LIVE;
               r_owner <= 1'b0;
               r_busy  <= bus_if.msg_req;
               for (int i = 0; i < 4; i++) r_seg[i] <= w_live_seg[i];
            end
            default: begin
               r_state <= ST_LIVE;
               r_owner <= 1'b0;
               r_busy  <= 1'b0;
               for (int i = 0; i < 4; i++) r_seg[i] <= SEG_BLANK;
            end
         endcase
      end
   end

   assign bus_if.msg_ack = r_ack;
   assign bus_if.owner   = r_owner;
   assign bus_if.busy    = r_busy;
   assign bus_if.seg0    = r_seg[0];
   assign bus_if.seg1    = r_seg[1];
   assign bus_if.seg2    = r_seg[2];
   assign bus_if.seg3    = r_seg[3];

endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench: three builds (hold 8, hold 16, hold 0) driven in lockstep
// against a tick-counting reference model of display ownership.
module tb_disp_scheduler;

   localparam int NDUT = 3;
   localparam int HOLD_TAB [NDUT] = '{8, 16, 0};
   localparam int DIV = 4;
   localparam logic [7:0] FONT_TB [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   typedef struct {
      int          d;
      logic [31:0] seg;
      logic        owner;
      logic        busy;
      logic        ack;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        s_tick = 1'b0;
   logic [15:0] s_live_val = 16'h0;
   logic        s_live_en = 1'b0;
   logic        s_msg_req = 1'b0;
   logic [31:0] s_msg_data = 32'h0;
   logic        s_msg_blink = 1'b0;

   logic [31:0] o_seg   [NDUT];
   logic        o_owner [NDUT];
   logic        o_busy  [NDUT];
   logic        o_ack   [NDUT];

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      disp_scheduler_if u_if ();
      assign u_if.tick      = s_tick;
      assign u_if.live_val  = s_live_val;
      assign u_if.live_en   = s_live_en;
      assign u_if.msg_req   = s_msg_req;
      assign u_if.msg_data  = s_msg_data;
      assign u_if.msg_blink = s_msg_blink;
      disp_scheduler #(.HOLD_TICKS(HOLD_TAB[gi]), .BLINK_DIV(DIV)) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .bus_if (u_if.slave)
      );
      assign o_seg[gi]   = {u_if.seg0, u_if.seg1, u_if.seg2, u_if.seg3};
      assign o_owner[gi] = u_if.owner;
      assign o_busy[gi]  = u_if.busy;
      assign o_ack[gi]   = u_if.msg_ack;
   end

   int n_assert = 0;
   int n_fail   = 0;
   exp_t sb[$];

   // Reference model: 0=live, 1=message showing, 2=waiting for request low.
   int          m_state [NDUT];
   int          m_seen  [NDUT];
   logic [31:0] m_data  [NDUT];
   logic        m_blink [NDUT];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] live_exp(input logic [15:0] v, input logic en);
      if (!en) return 32'hFFFF_FFFF;
      return {FONT_TB[v[15:12]], FONT_TB[v[11:8]], FONT_TB[v[7:4]], FONT_TB[v[3:0]]};
   endfunction

   // Drives inputs sampled by the coming edge and queues each build's expected outputs.
   task automatic apply(input logic t, input logic r, input logic [15:0] lv,
                        input logic le, input logic [31:0] md, input logic mb);
      exp_t e;
      int   hold;
      s_tick = t; s_msg_req = r; s_live_val = lv; s_live_en = le;
      s_msg_data = md; s_msg_blink = mb;
      for (int d = 0; d < NDUT; d++) begin
         hold = (HOLD_TAB[d] == 0) ? 1 : HOLD_TAB[d];
         e.d = d; e.ack = 1'b0; e.owner = 1'b0; e.busy = 1'b0;
         e.seg = live_exp(lv, le);
         case (m_state[d])
            0: if (r) begin
               m_state[d] = 1; m_data[d] = md; m_blink[d] = mb; m_seen[d] = 0;
               e.seg = md; e.owner = 1'b1; e.busy = 1'b1; e.ack = 1'b1;
            end
            1: begin
               if (t) m_seen[d]++;
               if (m_seen[d] == hold) begin
                  m_state[d] = r ? 2 : 0;
                  e.busy = r;
               end else begin
                  e.owner = 1'b1; e.busy = 1'b1;
                  e.seg = (m_blink[d] && ((m_seen[d] / DIV) % 2 == 1)) ? 32'hFFFF_FFFF : m_data[d];
               end
            end
            default: begin
               if (!r) m_state[d] = 0;
               e.busy = r;
            end
         endcase
         sb.push_back(e);
      end
   endtask

   task automatic drive(input logic t, input logic r, input logic [15:0] lv,
                        input logic le, input logic [31:0] md, input logic mb);
      @(negedge clk);
      #1;
      apply(t, r, lv, le, md, mb);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("d%0d.rst_seg", d), o_seg[d], 32'hFFFF_FFFF);
         chk($sformatf("d%0d.rst_owner", d), 32'(o_owner[d]), 32'd0);
         chk($sformatf("d%0d.rst_busy", d), 32'(o_busy[d]), 32'd0);
         chk($sformatf("d%0d.rst_ack", d), 32'(o_ack[d]), 32'd0);
         m_state[d] = 0; m_seen[d] = 0; m_data[d] = '0; m_blink[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      apply(1'b0, 1'b0, s_live_val, s_live_en, s_msg_data, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("d%0d.seg", e.d), o_seg[e.d], e.seg);
         chk($sformatf("d%0d.owner", e.d), 32'(o_owner[e.d]), 32'(e.owner));
         chk($sformatf("d%0d.busy", e.d), 32'(o_busy[e.d]), 32'(e.busy));
         chk($sformatf("d%0d.ack", e.d), 32'(o_ack[e.d]), 32'(e.ack));
      end
   end

   initial begin
      s_live_val = 16'h12AF;
      s_live_en  = 1'b1;
      reset_dut();
      // Plain overlay: tick in the accept cycle, re-request during SHOW, request held across exit.
      for (int c = 0; c < 40; c++)
         drive(c % 2 == 0, (c < 2) || (c == 5) || (c >= 14 && c < 22),
               16'h12AF, 1'b1, 32'hC0F9A4B0, 1'b0);
      // Blinking overlay with a live value change underneath.
      for (int c = 0; c < 50; c++)
         drive(c != 7, (c == 0) || (c == 10), (c < 25) ? 16'h12AF : 16'h0F3C,
               1'b1, 32'h868EC6A1, 1'b1);
      // Live blanked.
      for (int c = 0; c < 6; c++)
         drive(1'b1, 1'b0, 16'($urandom), 1'b0, 32'h0, 1'b0);
      // Reset in the middle of a shown message.
      for (int c = 0; c < 3; c++)
         drive(1'b1, c == 0, 16'h4567, 1'b1, 32'h92829980, 1'b0);
      reset_dut();
      for (int c = 0; c < 40; c++)
         drive(c % 2 == 1, (c == 2) || (c == 30), 16'($urandom), 1'b1,
               32'h8883C6A1, c > 20);
      drive(1'b0, 1'b0, 16'hBEEF, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      #2;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
